// File: rtl/mac_feeder.sv
// Job sequencer that clears a downstream MAC, streams joined A/B operand pairs into it,
// waits out the MAC latency and returns the accumulated result over a handshake.
module mac_feeder #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic [DATA_W-1:0] mac_a_o,
    output logic [DATA_W-1:0] mac_b_o,
    input  logic [ACC_W-1:0]  mac_c_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic              busy_o,
    output logic [2:0]        state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on the same channel's data, and a producer holds valid/data until taken.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                wait_q, wait_d;
    logic                mac_en_q, mac_en_d;
    logic [DATA_W-1:0]   mac_a_q, mac_a_d;
    logic [DATA_W-1:0]   mac_b_q, mac_b_d;
    logic [ACC_W-1:0]    res_data_q, res_data_d;
    logic                fire;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wait_d      = wait_q;
        mac_en_d    = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_data_d  = res_data_q;
        cmd_ready_o = 1'b0;
        mac_clr_o   = 1'b0;
        res_valid_o = 1'b0;
        fire        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    count_d = cmd_len_i;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clr_o = 1'b1;
                wait_d    = 1'b0;
                state_d   = (count_q != '0) ? S_FEED : S_WAIT;
            end
            S_FEED: begin
                // Pairs are joined: neither stream moves alone, and nothing moves during reset.
                fire = a_valid_i && b_valid_i && rst_n;
                if (fire) begin
                    mac_en_d = 1'b1;
                    mac_a_d  = a_data_i;
                    mac_b_d  = b_data_i;
                    count_d  = count_q - LEN_ONE;
                    if (count_q == LEN_ONE) begin
                        wait_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // First cycle covers the operand register, second the MAC's own latency.
                wait_d = 1'b1;
                if (wait_q) begin
                    wait_d     = 1'b0;
                    res_data_d = mac_c_i;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wait_q     <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            mac_en_q   <= mac_en_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            res_data_q <= res_data_d;
        end
    end

    assign a_ready_o  = fire;
    assign b_ready_o  = fire;
    assign mac_en_o   = mac_en_q;
    assign mac_a_o    = mac_a_q;
    assign mac_b_o    = mac_b_q;
    assign res_data_o = res_data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: a behavioural MAC closes the loop, and each job's
// result, latency and strobe counts are compared against hand-computed values.
module tb_mac_feeder;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 10;
    localparam int BUDGET = 2000;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] b_data;
    logic              mac_en;
    logic              mac_clr;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_c;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;
    logic [2:0]        state;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] a_arr [0:299];
    logic [DATA_W-1:0] b_arr [0:299];

    int   en_cnt  = 0;
    int   clr_cnt = 0;
    int   rdy_cnt = 0;
    logic overlap = 1'b0;

    mac_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
        .mac_en_o(mac_en), .mac_clr_o(mac_clr), .mac_a_o(mac_a), .mac_b_o(mac_b),
        .mac_c_i(mac_c),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .busy_o(busy), .state_o(state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream MAC: registered, wraps modulo 2^ACC_W
    logic [ACC_W-1:0] acc_q;
    always @(posedge clk) begin
        if (!rst_n)       acc_q <= '0;
        else if (mac_clr) acc_q <= '0;
        else if (mac_en)  acc_q <= acc_q + ACC_W'(mac_a) * ACC_W'(mac_b);
    end
    assign mac_c = acc_q;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mac_en)              en_cnt  <= en_cnt + 1;
        if (mac_clr)             clr_cnt <= clr_cnt + 1;
        if (a_ready || b_ready)  rdy_cnt <= rdy_cnt + 1;
        if (mac_en && mac_clr)   overlap <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one job: streams valid from the first FEED cycle, optional B stall after the
    // first pair, then holds res_ready low for 'hold' cycles while re-offering a command.
    task automatic run_job(input int len, input int stall, input int hold,
                           output logic [ACC_W-1:0] res, output int lat);
        int   idx;
        logic fired;
        idx       = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < BUDGET) begin
            a_valid = (idx < len);
            b_valid = (idx < len);
            a_data  = a_arr[idx];
            b_data  = b_arr[idx];
            if (stall > 0 && idx == 1) begin
                b_valid = 1'b0;
                stall--;
            end
            #1;
            fired = a_ready;
            if (a_valid && !b_valid) chk("join_no_a_alone", 32'(a_ready), 32'd0);
            tick();
            lat++;
            if (fired) idx++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        res = res_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_len   = LEN_W'(1);
            #1;
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            chk("busy_done", 32'(busy), 32'd1);
            tick();
            chk("res_valid_hold", 32'(res_valid), 32'd1);
            chk("res_data_hold", 32'(res_data), 32'(res));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [ACC_W-1:0] res;
        int lat, en0, clr0, rdy0, idx, guard;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; res_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Accumulate: 1*4+2*5+3*6 = 32, DONE reached 3+N edges after accept
        a_arr[0] = 8'd1; a_arr[1] = 8'd2; a_arr[2] = 8'd3;
        b_arr[0] = 8'd4; b_arr[1] = 8'd5; b_arr[2] = 8'd6;
        en0 = en_cnt; clr0 = clr_cnt; rdy0 = rdy_cnt;
        run_job(3, 0, 0, res, lat);
        chk("acc_result", 32'(res), 32'd32);
        chk("acc_latency", 32'(lat), 32'd6);
        chk("acc_en_count", 32'(en_cnt - en0), 32'd3);
        chk("acc_clr_count", 32'(clr_cnt - clr0), 32'd1);
        chk("acc_operand_hold", 32'(mac_a), 32'd3);

        // Zero length: cleared value, no enables, streams untouched
        en0 = en_cnt; clr0 = clr_cnt; rdy0 = rdy_cnt;
        run_job(0, 0, 0, res, lat);
        chk("zero_result", 32'(res), 32'd0);
        chk("zero_latency", 32'(lat), 32'd3);
        chk("zero_en_count", 32'(en_cnt - en0), 32'd0);
        chk("zero_clr_count", 32'(clr_cnt - clr0), 32'd1);
        chk("zero_ready_count", 32'(rdy_cnt - rdy0), 32'd0);

        // Join stall: B low 3 cycles after the first pair; 3*7+5*11 = 76
        a_arr[0] = 8'd3; a_arr[1] = 8'd5;
        b_arr[0] = 8'd7; b_arr[1] = 8'd11;
        en0 = en_cnt;
        run_job(2, 3, 0, res, lat);
        chk("stall_result", 32'(res), 32'd76);
        chk("stall_latency", 32'(lat), 32'd8);
        chk("stall_en_count", 32'(en_cnt - en0), 32'd2);

        // Wrap: 259*255*255 = 16841475, mod 2^24 = 64259
        for (int i = 0; i < 300; i++) begin a_arr[i] = 8'hFF; b_arr[i] = 8'hFF; end
        run_job(259, 0, 0, res, lat);
        chk("wrap_result", 32'(res), 32'd64259);
        chk("wrap_latency", 32'(lat), 32'd262);

        // Backpressure: result held 5 cycles, second command ignored; 10*1+20*2 = 50
        a_arr[0] = 8'd10; a_arr[1] = 8'd20;
        b_arr[0] = 8'd1;  b_arr[1] = 8'd2;
        run_job(2, 0, 5, res, lat);
        chk("bp_result", 32'(res), 32'd50);
        chk("bp_state_idle", 32'(state), 32'd0);

        // Mid-job reset after 2 of 5 pairs
        for (int i = 0; i < 5; i++) begin a_arr[i] = 8'(i + 1); b_arr[i] = 8'(i + 2); end
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(5);
        tick();
        cmd_valid = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 2 && guard < 20) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = a_arr[idx]; b_data = b_arr[idx];
            #1;
            if (a_ready) idx++;
            tick();
            guard++;
        end
        chk("midrst_two_fires", 32'(idx), 32'd2);
        a_data = a_arr[idx]; b_data = b_arr[idx];
        rst_n = 1'b0;
        #1;
        chk("midrst_no_consume", 32'(a_ready | b_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_a_ready", 32'(a_ready), 32'd0);
        chk("midrst_mac_en", 32'(mac_en), 32'd0);
        chk("midrst_mac_clr", 32'(mac_clr), 32'd0);
        chk("midrst_mac_a", 32'(mac_a), 32'd0);
        chk("midrst_mac_b", 32'(mac_b), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_data", 32'(res_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("midrst_no_result", 32'(res_valid), 32'd0);

        a_arr[0] = 8'd7; b_arr[0] = 8'd9;
        run_job(1, 0, 0, res, lat);
        chk("post_rst_result", 32'(res), 32'd63);
        chk("post_rst_latency", 32'(lat), 32'd4);

        tick();
        chk("en_clr_never_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
